insmem_loader: RTL and testbench

- Program-load writer for the byte-wide, big-endian instruction memory (2048 bytes, 8-bit entries, word fetch reads address..address+3 with the lowest address as the MSB).
- Accepts a byte stream over a valid/ready handshake: 6-byte header (base address, word count), then payload bytes.
- Issues one registered byte write per accepted payload byte into the memory's write port.
- Sits between the host/boot interface and the instruction memory; the processor is held off while busy=1.

---
 rtl/insmem_loader.sv | 180 ++++++++++++++++++
 tb/tb_insmem_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insmem_loader.sv
// Byte-stream program loader: 6-byte big-endian header (base, N words), then 4*N payload bytes written to instruction memory.
// Latency: write strobe registered on the edge that accepts each payload byte; done pulses two cycles after the last write.
// Backpressure: in_ready depends on state only; upstream holds in_valid/in_byte until accepted.
module insmem_loader #(
    parameter int MEM_BYTES = 2048,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int REM_W = CNT_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_ADDR,
        S_HDR_LEN,
        S_DATA,
        S_FINISH,
        S_FINISH2,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         hdr_cnt_q, hdr_cnt_d;
    logic [31:0]        base_q, base_d;
    logic [7:0]         len_hi_q, len_hi_d;
    logic [31:0]        ptr_q, ptr_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic               wr_en_q, wr_en_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               accept;
    logic [CNT_W-1:0]   n_full;
    logic [33:0]        end_addr;

    always_comb begin
        in_ready = (state_q == S_HDR_ADDR) || (state_q == S_HDR_LEN) || (state_q == S_DATA);
    end

    assign accept   = in_valid & in_ready;
    assign n_full   = CNT_W'({len_hi_q, in_byte});
    // Evaluated wide enough that a huge N cannot wrap back into range.
    assign end_addr = {2'b00, base_q} + (34'(n_full) << 2);

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        base_d    = base_q;
        len_hi_d  = len_hi_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_d   = S_HDR_ADDR;
                    hdr_cnt_d = 2'd0;
                    busy_d    = 1'b1;
                    error_d   = 1'b0;
                end
            end
            S_HDR_ADDR: begin
                if (accept) begin
                    base_d = {base_q[23:0], in_byte};
                    if (hdr_cnt_q == 2'd3) begin
                        state_d   = S_HDR_LEN;
                        hdr_cnt_d = 2'd0;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 2'd1;
                    end
                end
            end
            S_HDR_LEN: begin
                if (accept) begin
                    len_hi_d = in_byte;
                    if (hdr_cnt_q == 2'd1) begin
                        hdr_cnt_d = 2'd0;
                        if (base_q[1:0] != 2'b00 || end_addr > 34'(MEM_BYTES)) begin
                            state_d = S_ERROR;
                            error_d = 1'b1;
                            busy_d  = 1'b0;
                        end else if (n_full == '0) begin
                            state_d = S_FINISH;
                        end else begin
                            state_d = S_DATA;
                            ptr_d   = base_q;
                            rem_d   = {n_full, 2'b00};
                        end
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 2'd1;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = in_byte;
                    ptr_d     = ptr_q + 32'd1;
                    rem_d     = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        state_d = S_FINISH;
                    end
                end
            end
            // Two quiet cycles put done exactly two cycles after the final write.
            S_FINISH: begin
                state_d = S_FINISH2;
            end
            S_FINISH2: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hdr_cnt_q <= 2'd0;
            base_q    <= 32'd0;
            len_hi_q  <= 8'd0;
            ptr_q     <= 32'd0;
            rem_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 32'd0;
            wr_data_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            base_q    <= base_d;
            len_hi_q  <= len_hi_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_insmem_loader.sv
// Bench for insmem_loader: scenario tasks with a session-level reference model (expected writes, flags, done timing).
module tb_insmem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  mem [0:2047];
    int          mon_addr[$];
    logic [7:0]  mon_data[$];
    int          mon_wcyc[$];
    int          mon_dcyc[$];

    insmem_loader #(.MEM_BYTES(2048), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observes the memory write port and done pulses; models the byte memory.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            checks++;
            if (wr_addr >= 32'd2048) begin
                errors++;
                $display("FAIL wr_addr_range: got %0h required < 800", wr_addr);
            end else begin
                mem[wr_addr[10:0]] = wr_data;
            end
            mon_addr.push_back(int'(wr_addr));
            mon_data.push_back(wr_data);
            mon_wcyc.push_back(cyc);
        end
        if (done === 1'b1) mon_dcyc.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        mon_addr.delete();
        mon_data.delete();
        mon_wcyc.delete();
        mon_dcyc.delete();
    endtask

    // mode: 0 = in_valid held, 1 = pattern 1,0,0 repeating, 2 = random gaps
    task automatic run_session(input logic [31:0] base, input int n, input logic [7:0] pl[$],
                               input int mode, input bit start_mid, input string name);
        logic [7:0] stream[$];
        logic [33:0] endv;
        bit exp_err, rdy_bad, v;
        int idx, k, exp_n;
        endv    = {2'b00, base} + 34'(n) * 34'd4;
        exp_err = (base[1:0] != 2'b00) || (endv > 34'd2048);
        exp_n   = exp_err ? 0 : 4 * n;
        stream.push_back(base[31:24]);
        stream.push_back(base[23:16]);
        stream.push_back(base[15:8]);
        stream.push_back(base[7:0]);
        stream.push_back(8'((n >> 8) & 255));
        stream.push_back(8'(n & 255));
        if (!exp_err) for (int i = 0; i < exp_n; i++) stream.push_back(pl[i]);
        mon_clear();

        // Offered byte together with start must not be taken.
        start = 1'b1; in_valid = 1'b1; in_byte = 8'($urandom);
        tick();
        start = 1'b0; in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_start: busy=%b error=%b required busy=1 error=0", name, busy, error);
        end

        idx = 0; k = 0; rdy_bad = 0;
        while (idx < stream.size() && k < 4000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (k % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_byte  = v ? stream[idx] : 8'($urandom);
            start    = start_mid && (idx == 2);
            if (v && in_ready !== 1'b1) rdy_bad = 1'b1;
            tick();
            if (v) idx++;
            k++;
        end
        in_valid = 1'b0; start = 1'b0;
        checks++;
        if (rdy_bad || idx != stream.size()) begin
            errors++;
            $display("FAIL %s in_ready_stream: bytes taken %0d of %0d, ready_low_seen=%b required 0", name, idx, stream.size(), rdy_bad);
        end
        repeat (6) tick();

        checks++;
        if (error !== exp_err) begin
            errors++;
            $display("FAIL %s error_flag: got %b required %b", name, error, exp_err);
        end
        checks++;
        if (mon_addr.size() != exp_n) begin
            errors++;
            $display("FAIL %s write_count: got %0d required %0d", name, mon_addr.size(), exp_n);
        end else begin
            for (int i = 0; i < exp_n; i++) begin
                checks++;
                if (mon_addr[i] != int'(base) + i || mon_data[i] !== pl[i]) begin
                    errors++;
                    $display("FAIL %s write_%0d: got addr %0h data %02h required addr %0h data %02h",
                             name, i, mon_addr[i], mon_data[i], int'(base) + i, pl[i]);
                end
            end
        end
        checks++;
        if (mon_dcyc.size() != (exp_err ? 0 : 1)) begin
            errors++;
            $display("FAIL %s done_count: got %0d required %0d", name, mon_dcyc.size(), exp_err ? 0 : 1);
        end else if (!exp_err && exp_n > 0 && mon_wcyc.size() > 0) begin
            checks++;
            if (mon_dcyc[0] - mon_wcyc[mon_wcyc.size() - 1] != 2) begin
                errors++;
                $display("FAIL %s done_latency: got %0d required 2", name, mon_dcyc[0] - mon_wcyc[mon_wcyc.size() - 1]);
            end
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_outputs: busy=%b in_ready=%b wr_en=%b done=%b required all 0", name, busy, in_ready, wr_en, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        #12;
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, wr_en, busy, done, error} !== 5'b0 || wr_addr !== 32'd0 || wr_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b we=%b busy=%b done=%b err=%b addr=%0h data=%0h required all 0",
                     in_ready, wr_en, busy, done, error, wr_addr, wr_data);
        end
        tick(); tick();
        reset = 1'b0;
        in_valid = 1'b1; in_byte = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_%0d: in_ready=%b wr_en=%b busy=%b required 0", i, in_ready, wr_en, busy);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_nominal();
        logic [7:0] pl[$];
        pl = '{8'h01, 8'h4B, 8'h48, 8'h20, 8'h01, 8'h4B, 8'h48, 8'h22};
        run_session(32'h8, 2, pl, 0, 1'b0, "nominal");
        checks++;
        if ({mem[8], mem[9], mem[10], mem[11]} !== 32'h014B4820 || {mem[12], mem[13], mem[14], mem[15]} !== 32'h014B4822) begin
            errors++;
            $display("FAIL nominal_fetch: got %08h %08h required 014b4820 014b4822",
                     {mem[8], mem[9], mem[10], mem[11]}, {mem[12], mem[13], mem[14], mem[15]});
        end
    endtask

    task automatic test_flow_control();
        logic [7:0] pl[$];
        pl = '{8'h01, 8'h4B, 8'h48, 8'h20, 8'h01, 8'h4B, 8'h48, 8'h22};
        for (int i = 8; i < 16; i++) mem[i] = 8'h00;
        run_session(32'h8, 2, pl, 1, 1'b0, "flow");
        checks++;
        if ({mem[8], mem[9], mem[10], mem[11]} !== 32'h014B4820 || {mem[12], mem[13], mem[14], mem[15]} !== 32'h014B4822) begin
            errors++;
            $display("FAIL flow_fetch: got %08h %08h required 014b4820 014b4822",
                     {mem[8], mem[9], mem[10], mem[11]}, {mem[12], mem[13], mem[14], mem[15]});
        end
    endtask

    task automatic test_range();
        logic [7:0] pl[$];
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        run_session(32'h7FC, 2, pl, 0, 1'b0, "range_over");
        run_session(32'h7F8, 2, pl, 2, 1'b0, "range_edge");
        checks++;
        if (mem[2047] !== pl[7]) begin
            errors++;
            $display("FAIL range_last_byte: got %02h required %02h", mem[2047], pl[7]);
        end
        run_session(32'h0, 65535, pl, 0, 1'b0, "range_max_n");
        run_session(32'hFFFF_FFFC, 1, pl, 0, 1'b0, "range_wrap");
    endtask

    task automatic test_align_zero();
        logic [7:0] pl[$];
        for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
        run_session(32'h2, 1, pl, 0, 1'b0, "misaligned");
        run_session(32'h0, 0, pl, 0, 1'b0, "zero_len");
    endtask

    task automatic test_abort();
        logic [7:0] hdr[$];
        logic [7:0] pl[$];
        hdr = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        mon_clear();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_byte = hdr[i];
            start = (i == 1);
            tick();
        end
        in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: wr_en=%b busy=%b in_ready=%b done=%b required 0", wr_en, busy, in_ready, done);
        end
        checks++;
        if (mon_addr.size() != 3 || mon_addr[0] != 32'h100 || mon_addr[2] != 32'h102 || mon_data[2] !== 8'h33) begin
            errors++;
            $display("FAIL abort_writes: got %0d writes required 3 at 100..102", mon_addr.size());
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        run_session(32'h100, 2, pl, 0, 1'b1, "after_abort");
    endtask

    task automatic test_random();
        logic [7:0] pl[$];
        logic [31:0] base;
        int n, sel;
        for (int s = 0; s < 24; s++) begin
            pl.delete();
            n   = $urandom_range(0, 6);
            sel = $urandom_range(0, 7);
            if (sel == 0)      base = 32'($urandom_range(0, 2047));
            else if (sel == 1) base = 32'h800 - 32'(4 * $urandom_range(0, 7));
            else               base = 32'($urandom_range(0, 511)) << 2;
            for (int i = 0; i < 4 * n; i++) pl.push_back(8'($urandom));
            run_session(base, n, pl, 2, s[0], $sformatf("random_%0d", s));
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_flow_control();
        test_range();
        test_align_zero();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
